// File: rtl/tag_array_ctrl.sv
// tag_array_ctrl: controller for a direct-mapped cache tag SRAM (one 21-bit
// entry {valid, dirty, tag} per set). It sweeps the array to zero after
// reset. It then serves one request at a time: LOOKUP, FILL, INVAL and
// MARK_DIRTY, each over the single-port SRAM interface.
// Optional build macro: TAG_CTRL_STATS_EN adds saturating LOOKUP hit/miss
// counters on the hit_count / miss_count outputs.
module tag_array_ctrl #(
   parameter int ADDR_WIDTH   = 32,
   parameter int OFFSET_WIDTH = 6,
   parameter int INDEX_WIDTH  = 7,
   parameter int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             req_op,
   input  logic [ADDR_WIDTH-1:0]  req_addr,
   input  logic                   req_dirty,
   output logic                   resp_valid,
   output logic                   resp_hit,
   output logic                   resp_dirty,
   output logic [TAG_WIDTH-1:0]   resp_tag,
   output logic                   sram_csb0,
   output logic                   sram_web0,
   output logic [INDEX_WIDTH-1:0] sram_addr0,
   output logic [TAG_WIDTH+1:0]   sram_din0,
   input  logic [TAG_WIDTH+1:0]   sram_dout0,
   output logic                   init_done
`ifdef TAG_CTRL_STATS_EN
   ,
   output logic [15:0]            hit_count,
   output logic [15:0]            miss_count
`endif
);

   localparam logic [1:0] OP_LOOKUP = 2'b00;
   localparam logic [1:0] OP_FILL   = 2'b01;
   localparam logic [1:0] OP_INVAL  = 2'b10;
   localparam logic [1:0] OP_MARK   = 2'b11;
   localparam logic [INDEX_WIDTH-1:0] SWEEP_LAST = {INDEX_WIDTH{1'b1}};

   typedef enum logic [1:0] {INIT, IDLE, RD, WB} state_t;

   state_t                 state, state_nxt;
   logic [INDEX_WIDTH-1:0] sweep_idx;
   logic                   ack_pend;
   logic                   accept;

   // Request fields; the byte offset within a line plays no part in tagging.
   logic [INDEX_WIDTH-1:0] req_index;
   logic [TAG_WIDTH-1:0]   req_tag;
   logic                   unused_offset;

   // Request captured at accept so the bus may change while the op runs.
   logic [INDEX_WIDTH-1:0] idx_p0;
   logic [TAG_WIDTH-1:0]   tag_p0;
   logic [1:0]             op_p0;

   // Fields of the entry returned by the SRAM the cycle after a read.
   logic                   ent_valid;
   logic                   ent_dirty;
   logic [TAG_WIDTH-1:0]   ent_tag;
   logic                   lookup_hit;

   assign req_index     = req_addr[OFFSET_WIDTH +: INDEX_WIDTH];
   assign req_tag       = req_addr[OFFSET_WIDTH+INDEX_WIDTH +: TAG_WIDTH];
   assign unused_offset = ^req_addr[OFFSET_WIDTH-1:0];

   assign ent_valid  = sram_dout0[TAG_WIDTH+1];
   assign ent_dirty  = sram_dout0[TAG_WIDTH];
   assign ent_tag    = sram_dout0[TAG_WIDTH-1:0];
   assign lookup_hit = ent_valid && (ent_tag == tag_p0);

   assign accept = req_valid && req_ready;

   // State register; reset restarts the sweep and drops any op in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= INIT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, handshake and SRAM port drive. Reset forces the SRAM idle
   // at once, even though the state already reads INIT.
   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      sram_csb0  = 1'b1;
      sram_web0  = 1'b1;
      sram_addr0 = '0;
      sram_din0  = '0;
      if (!rst) begin
         case (state)
            INIT: begin
               sram_csb0  = 1'b0;
               sram_web0  = 1'b0;
               sram_addr0 = sweep_idx;
               if (sweep_idx == SWEEP_LAST) begin
                  state_nxt = IDLE;
               end
            end
            IDLE: begin
               req_ready = 1'b1;
               if (req_valid) begin
                  sram_csb0  = 1'b0;
                  sram_addr0 = req_index;
                  case (req_op)
                     OP_FILL: begin
                        sram_web0 = 1'b0;
                        sram_din0 = {1'b1, req_dirty, req_tag};
                     end
                     OP_INVAL: begin
                        sram_web0 = 1'b0;
                     end
                     default: begin
                        // LOOKUP and MARK_DIRTY both start with a read.
                        state_nxt = RD;
                     end
                  endcase
               end
            end
            RD: begin
               state_nxt = (op_p0 == OP_MARK && lookup_hit) ? WB : IDLE;
            end
            WB: begin
               sram_csb0  = 1'b0;
               sram_web0  = 1'b0;
               sram_addr0 = idx_p0;
               sram_din0  = {2'b11, tag_p0};
               state_nxt  = IDLE;
            end
            default: state_nxt = INIT;
         endcase
      end
   end

   // Sweep pointer and init_done; the pointer stops mattering once IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sweep_idx <= '0;
         init_done <= 1'b0;
      end else if (state == INIT) begin
         sweep_idx <= sweep_idx + INDEX_WIDTH'(1);
         if (sweep_idx == SWEEP_LAST) begin
            init_done <= 1'b1;
         end
      end
   end

   // Capture the request at accept; pure data, so no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         idx_p0 <= req_index;
         tag_p0 <= req_tag;
         op_p0  <= req_op;
      end
   end

   // Response pulse. FILL/INVAL answer one cycle after the write; reads
   // answer from the SRAM output; a MARK_DIRTY hit answers from WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_pend   <= 1'b0;
         resp_valid <= 1'b0;
         resp_hit   <= 1'b0;
         resp_dirty <= 1'b0;
         resp_tag   <= '0;
      end else begin
         resp_valid <= 1'b0;
         ack_pend   <= accept && (req_op == OP_FILL || req_op == OP_INVAL);
         if (ack_pend) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b0;
            resp_dirty <= 1'b0;
            resp_tag   <= '0;
         end else if (state == RD) begin
            if (!(op_p0 == OP_MARK && lookup_hit)) begin
               resp_valid <= 1'b1;
               resp_hit   <= lookup_hit;
               resp_dirty <= ent_dirty;
               resp_tag   <= ent_tag;
            end
         end else if (state == WB) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_dirty <= 1'b1;
            resp_tag   <= tag_p0;
         end
      end
   end

`ifdef TAG_CTRL_STATS_EN
   // Saturating hit/miss counters over LOOKUP responses only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (state == RD && op_p0 == OP_LOOKUP) begin
         if (lookup_hit) begin
            if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
         end else begin
            if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
         end
      end
   end
`endif

endmodule
